// File: rtl/lamp_mon_pkg.sv
// Shared types and constants for the lamp-bar sequence monitor.
package lamp_mon_pkg;

    localparam int unsigned NUM_LAMPS = 16;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned CODE_W    = 3;
    localparam int unsigned PHASE_W   = 4;
    localparam int unsigned STAT_W    = 16;
    localparam int unsigned UP1_MAX   = 6;

    // Ten phases need a 4-bit code.
    typedef enum logic [PHASE_W-1:0] {
        IDLE = 4'd0,
        UP1  = 4'd1,
        DN1  = 4'd2,
        UP2  = 4'd3,
        KDN2 = 4'd4,
        DN2  = 4'd5,
        UP3  = 4'd6,
        KDN3 = 4'd7,
        DN3  = 4'd8,
        SYNC = 4'd9
    } phase_t;

    localparam logic [CODE_W-1:0] ERR_NONE     = 3'd0;
    localparam logic [CODE_W-1:0] ERR_PATTERN  = 3'd1;
    localparam logic [CODE_W-1:0] ERR_STEP     = 3'd2;
    localparam logic [CODE_W-1:0] ERR_REVERSAL = 3'd3;
    localparam logic [CODE_W-1:0] ERR_RANGE    = 3'd4;
    localparam logic [CODE_W-1:0] ERR_IDLE     = 3'd5;

endpackage

// File: rtl/therm_decode.sv
// Thermometer-code decoder: lamp count plus a flag for a legal 2^n-1 pattern.
module therm_decode
    import lamp_mon_pkg::*;
(
    input  logic [NUM_LAMPS-1:0] bar,
    output logic [CNT_W-1:0]     cnt,
    output logic                 legal
);

    localparam int unsigned INC_W = NUM_LAMPS + 1;

    logic [INC_W-1:0] bar_inc;

    // 2^n-1 has no bit in common with itself plus one.
    assign bar_inc = {1'b0, bar} + INC_W'(1);
    assign legal   = (bar & bar_inc[NUM_LAMPS-1:0]) == '0;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_LAMPS; i++) begin
            cnt = cnt + CNT_W'(bar[i]);
        end
    end

endmodule

// File: rtl/lamp_seq_monitor.sv
// Passive checker decoding the flasher lamp bar into sequence phase, events and errors.
// Optional statistics counters are built when LAMP_SEQ_MONITOR_STATS_EN is defined.
module lamp_seq_monitor
    import lamp_mon_pkg::*;
#(
    parameter int unsigned KICK_LO = 6,
    parameter int unsigned KICK_HI = 11,
    parameter int unsigned MID_MIN = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LAMPS-1:0] lamps,
    output logic [CNT_W-1:0]    count,
    output logic                dir,
    output logic [PHASE_W-1:0]  phase,
    output logic                kick_pulse,
    output logic                done_pulse,
    output logic                err_pulse,
    output logic [CODE_W-1:0]   err_code,
    output logic [STAT_W-1:0]   seq_cnt,
    output logic [STAT_W-1:0]   kick_cnt
);

    logic [NUM_LAMPS-1:0] lamps_q;
    logic [CNT_W-1:0]     dec_cnt;
    logic                 dec_legal;

    phase_t             state_q, state_d;
    logic [CNT_W-1:0]   count_d;
    logic               dir_d;
    logic               kick_d, done_d, err_d;
    logic [CODE_W-1:0]  code_d;

    logic step_up, step_dn, step_hold;
    logic at_zero, at_lo, at_hi, at_mid, at_full, at_up1_max;

    therm_decode u_decode (
        .bar   (lamps_q),
        .cnt   (dec_cnt),
        .legal (dec_legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lamps_q <= '0;
        end else begin
            lamps_q <= lamps;
        end
    end

    // Reversal points are judged at the previous count, where the turn happens.
    assign step_up    = dec_cnt == count + CNT_W'(1);
    assign step_dn    = dec_cnt + CNT_W'(1) == count;
    assign step_hold  = dec_cnt == count;
    assign at_zero    = count == '0;
    assign at_lo      = count == CNT_W'(KICK_LO);
    assign at_hi      = count == CNT_W'(KICK_HI);
    assign at_mid     = count == CNT_W'(MID_MIN);
    assign at_full    = count == CNT_W'(NUM_LAMPS);
    assign at_up1_max = count == CNT_W'(UP1_MAX);

    always_comb begin
        state_d = state_q;
        count_d = count;
        dir_d   = dir;
        kick_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;

        if (dec_legal) begin
            count_d = dec_cnt;
            dir_d   = dec_cnt > count;
        end

        if (state_q == SYNC) begin
            if (dec_legal && dec_cnt == '0) state_d = IDLE;
        end else if (!dec_legal) begin
            code_d = ERR_PATTERN;
        end else if (state_q == IDLE) begin
            if (step_up && at_zero)  state_d = UP1;
            else if (!step_hold)     code_d  = ERR_IDLE;
        end else if (!(step_up || step_dn || step_hold)) begin
            code_d = ERR_STEP;
        end else if (!step_hold) begin
            case (state_q)
                UP1: begin
                    if (step_up) begin
                        if (dec_cnt > CNT_W'(UP1_MAX)) code_d = ERR_RANGE;
                    end else if (at_up1_max) state_d = DN1;
                    else code_d = ERR_REVERSAL;
                end
                DN1: begin
                    if (step_up) begin
                        if (at_zero) state_d = UP2;
                        else         code_d  = ERR_REVERSAL;
                    end
                end
                UP2: begin
                    if (step_up) begin
                        if (dec_cnt > CNT_W'(KICK_HI)) code_d = ERR_RANGE;
                    end else if (at_hi) begin
                        state_d = DN2;
                    end else if (at_lo) begin
                        state_d = KDN2;
                        kick_d  = 1'b1;
                    end else begin
                        code_d = ERR_REVERSAL;
                    end
                end
                KDN2: begin
                    if (step_up) begin
                        if (at_zero) state_d = UP2;
                        else         code_d  = ERR_REVERSAL;
                    end
                end
                DN2: begin
                    if (step_dn) begin
                        if (dec_cnt < CNT_W'(MID_MIN)) code_d = ERR_RANGE;
                    end else if (at_mid) state_d = UP3;
                    else code_d = ERR_REVERSAL;
                end
                UP3: begin
                    if (step_dn) begin
                        if (at_full) begin
                            state_d = DN3;
                        end else if (at_lo || at_hi) begin
                            state_d = KDN3;
                            kick_d  = 1'b1;
                        end else begin
                            code_d = ERR_REVERSAL;
                        end
                    end
                end
                KDN3: begin
                    if (step_dn) begin
                        if (dec_cnt < CNT_W'(MID_MIN)) code_d = ERR_RANGE;
                    end else if (at_mid) state_d = UP3;
                    else code_d = ERR_REVERSAL;
                end
                DN3: begin
                    if (step_up) begin
                        code_d = ERR_REVERSAL;
                    end else if (dec_cnt == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (code_d != ERR_NONE) begin
            err_d   = 1'b1;
            state_d = SYNC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count      <= '0;
            dir        <= 1'b0;
            kick_pulse <= 1'b0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            count      <= count_d;
            dir        <= dir_d;
            kick_pulse <= kick_d;
            done_pulse <= done_d;
            err_pulse  <= err_d;
            if (err_d) err_code <= code_d;
        end
    end

    assign phase = state_q;

`ifdef LAMP_SEQ_MONITOR_STATS_EN
    logic [STAT_W-1:0] seq_q, kick_q;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_q  <= '0;
            kick_q <= '0;
        end else begin
            if (done_d && seq_q != '1)  seq_q  <= seq_q + STAT_W'(1);
            if (kick_d && kick_q != '1) kick_q <= kick_q + STAT_W'(1);
        end
    end

    assign seq_cnt  = seq_q;
    assign kick_cnt = kick_q;
`else
    assign seq_cnt  = '0;
    assign kick_cnt = '0;
`endif

endmodule
